// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and the burst-boundary constants.
// Also holds the read-DMA state type so every file agrees on it.
package axi_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [3:0] CACHE_MODIFIABLE_BUFFERABLE = 4'b0011;

  localparam int BOUNDARY_4K = 4096;
  localparam int BOUNDARY_4K_LOG2 = 12;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } dma_state_e;

  // A narrow address space has a smaller wrap than 4 KB.
  function automatic int bnd_log2(input int aw);
    return (aw < BOUNDARY_4K_LOG2) ? aw : BOUNDARY_4K_LOG2;
  endfunction

endpackage

// File: rtl/axi_burst_split.sv
// Combinational INCR burst sizer: beats = min(rem, max, to boundary).
// In: addr (word aligned), rem. Out: arlen, beats, next_addr.
module axi_burst_split
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH    = 16,
  parameter int LEN_WIDTH     = 16,
  parameter int STRB_WIDTH    = 4,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [LEN_WIDTH-1:0]  rem,
  output logic [7:0]            arlen,
  output logic [8:0]            beats,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  localparam int BND_LOG2 = bnd_log2(ADDR_WIDTH);
  localparam int BND      = 1 << BND_LOG2;
  localparam int SIZE     = $clog2(STRB_WIDTH);

  logic [31:0] off;
  logic [31:0] to_bnd;
  logic [31:0] cnt;

  always_comb begin
    off    = 32'(addr) & 32'(BND - 1);
    to_bnd = (32'(BND) - off) >> SIZE;
    cnt    = 32'(rem);
    if (cnt > 32'(MAX_BURST_LEN)) cnt = 32'(MAX_BURST_LEN);
    if (cnt > to_bnd) cnt = to_bnd;
  end

  assign beats     = 9'(cnt);
  assign arlen     = 8'(cnt - 32'd1);
  assign next_addr = addr + ADDR_WIDTH'(cnt << SIZE);

endmodule

// File: rtl/axi_rd_dma.sv
// Descriptor-driven AXI4 read DMA streaming words out on AXI-Stream.
// Ports: s_desc_* in, m_status_* out, m_axi_ar*/r* master, m_axis_* out.
module axi_rd_dma
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 16,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int ID_WIDTH      = 8,
  parameter int AXI_ID        = 0,
  parameter int LEN_WIDTH     = 16,
  parameter int TAG_WIDTH     = 8,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_desc_addr,
  input  logic [LEN_WIDTH-1:0]  s_desc_len,
  input  logic [TAG_WIDTH-1:0]  s_desc_tag,
  input  logic                  s_desc_valid,
  output logic                  s_desc_ready,
  output logic [TAG_WIDTH-1:0]  m_status_tag,
  output logic                  m_status_error,
  output logic                  m_status_valid,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  busy
);

  localparam int SIZE = $clog2(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN =
    ~ADDR_WIDTH'(STRB_WIDTH - 1);

  dma_state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic                  err_q, err_d;
  logic                  arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [7:0]            arlen_q, arlen_d;
  logic                  rdy_q, rdy_d;
  logic                  st_valid_q, st_valid_d;
  logic [TAG_WIDTH-1:0]  st_tag_q, st_tag_d;
  logic                  st_err_q, st_err_d;

  logic [ADDR_WIDTH-1:0] desc_addr_al;
  logic [ADDR_WIDTH-1:0] sp_addr;
  logic [LEN_WIDTH-1:0]  sp_rem;
  logic [7:0]            sp_arlen;
  logic [8:0]            sp_beats;
  logic [ADDR_WIDTH-1:0] sp_next;
  logic                  in_data;
  logic                  desc_fire;
  logic                  beat;
  logic                  beat_err;
  logic                  load;
  logic                  unused_rid;

  assign unused_rid = ^m_axi_rid;

  assign desc_addr_al = s_desc_addr & ALIGN;

  // First burst sizes straight from the descriptor; later ones
  // from the running address and remaining count.
  assign sp_addr = (state_q == IDLE) ? desc_addr_al : addr_q;
  assign sp_rem  = (state_q == IDLE) ? s_desc_len : rem_q;

  axi_burst_split #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .LEN_WIDTH    (LEN_WIDTH),
    .STRB_WIDTH   (STRB_WIDTH),
    .MAX_BURST_LEN(MAX_BURST_LEN)
  ) u_split (
    .addr     (sp_addr),
    .rem      (sp_rem),
    .arlen    (sp_arlen),
    .beats    (sp_beats),
    .next_addr(sp_next)
  );

  assign in_data   = (state_q == DATA);
  assign desc_fire = rdy_q && s_desc_valid;
  assign beat      = in_data && m_axi_rvalid && m_axis_tready;
  assign beat_err  = beat && (m_axi_rresp != RESP_OKAY);

  assign m_axi_arid    = ID_WIDTH'(AXI_ID);
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arsize  = 3'(SIZE);
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = CACHE_MODIFIABLE_BUFFERABLE;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;

  assign m_axi_rready  = in_data && m_axis_tready;
  assign m_axis_tvalid = in_data && m_axi_rvalid;
  assign m_axis_tdata  = m_axi_rdata;
  assign m_axis_tlast  = in_data && m_axi_rlast && (rem_q == '0);

  assign s_desc_ready   = rdy_q;
  assign m_status_valid = st_valid_q;
  assign m_status_tag   = st_tag_q;
  assign m_status_error = st_err_q;
  assign busy           = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    tag_d      = tag_q;
    err_d      = err_q;
    arvalid_d  = arvalid_q;
    araddr_d   = araddr_q;
    arlen_d    = arlen_q;
    rdy_d      = rdy_q;
    st_valid_d = 1'b0;
    st_tag_d   = st_tag_q;
    st_err_d   = st_err_q;
    load       = 1'b0;
    case (state_q)
      IDLE: begin
        rdy_d = 1'b1;
        if (desc_fire) begin
          tag_d = s_desc_tag;
          err_d = 1'b0;
          if (s_desc_len == '0) begin
            st_valid_d = 1'b1;
            st_tag_d   = s_desc_tag;
            st_err_d   = 1'b0;
          end else begin
            load    = 1'b1;
            state_d = ADDR;
            rdy_d   = 1'b0;
          end
        end
      end
      ADDR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (beat_err) err_d = 1'b1;
        if (beat && m_axi_rlast) begin
          if (rem_q != '0) begin
            load    = 1'b1;
            state_d = ADDR;
          end else begin
            st_valid_d = 1'b1;
            st_tag_d   = tag_q;
            st_err_d   = err_q | beat_err;
            state_d    = IDLE;
            rdy_d      = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // AR payload is registered so it stays stable until arready.
    if (load) begin
      araddr_d  = sp_addr;
      arlen_d   = sp_arlen;
      arvalid_d = 1'b1;
      addr_d    = sp_next;
      rem_d     = sp_rem - LEN_WIDTH'(sp_beats);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      tag_q      <= '0;
      err_q      <= 1'b0;
      arvalid_q  <= 1'b0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      rdy_q      <= 1'b0;
      st_valid_q <= 1'b0;
      st_tag_q   <= '0;
      st_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      tag_q      <= tag_d;
      err_q      <= err_d;
      arvalid_q  <= arvalid_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      rdy_q      <= rdy_d;
      st_valid_q <= st_valid_d;
      st_tag_q   <= st_tag_d;
      st_err_q   <= st_err_d;
    end
  end

endmodule

// File: doc/axi_rd_dma.md
# axi_rd_dma

Descriptor-driven AXI4 read master that fetches a contiguous block of words from an AXI4 memory slave, such as the on-chip AXI RAM holding layer configuration. It forwards the words as an AXI-Stream to the compute datapath. It splits each request into INCR bursts that respect maximum burst length and 4 KB boundaries, and reports completion per descriptor with a tag and a sticky error flag.

## Interface
- DATA_WIDTH, 32, AXI/stream data width
- ADDR_WIDTH, 16, AXI byte-address width
- STRB_WIDTH, DATA_WIDTH/8, bytes per word (power of two)
- ID_WIDTH, 8, AXI ID width
- AXI_ID, 0, constant ARID driven on every burst
- LEN_WIDTH, 16, descriptor length width (in words)
- TAG_WIDTH, 8, descriptor tag width
- MAX_BURST_LEN, 16, max beats per burst (1..256)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- s_desc_addr  in  ADDR_WIDTH  start byte address; low log2(STRB_WIDTH) bits ignored
- s_desc_len  in  LEN_WIDTH  word count
- s_desc_tag  in  TAG_WIDTH  echoed in status
- s_desc_valid / s_desc_ready  in / out  1  descriptor handshake
- m_status_tag  out  TAG_WIDTH  tag of completed descriptor
- m_status_error  out  1  any RRESP != OKAY during descriptor
- m_status_valid  out  1  one-cycle completion pulse, no backpressure
- m_axi_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot  out  ID_WIDTH/ADDR_WIDTH/8/3/2/1/4/3  AR payload
- m_axi_arvalid / m_axi_arready  out / in  1  AR handshake
- m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast  in  ID_WIDTH/DATA_WIDTH/2/1  R payload (rid ignored)
- m_axi_rvalid / m_axi_rready  in / out  1  R handshake
- m_axis_tdata  out  DATA_WIDTH  stream data
- m_axis_tlast  out  1  final word of descriptor
- m_axis_tvalid / m_axis_tready  out / in  1  stream handshake
- busy  out  1  high when not IDLE

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE: s_desc_ready=1. On accept, latch addr (word-aligned), len, tag, and clear the error flag.
  - len==0: pulse status next cycle (error=0), stay IDLE, no AXI traffic.
  - Otherwise go to ADDR.
- ADDR:
  - Per-burst beats = min(remaining, MAX_BURST_LEN, words to next 2^min(12,ADDR_WIDTH)-byte boundary).
  - arlen=beats-1, arsize=log2(STRB_WIDTH), arburst=2'b01, arlock=0, arcache=4'b0011, arprot=0, arid=AXI_ID.
  - Hold arvalid with a stable payload until arready; then go to DATA. Address advances by beats*STRB_WIDTH and remaining decrements by beats.
- DATA:
  - Combinational pass-through: m_axis_tdata=rdata; m_axis_tvalid=rvalid; m_axi_rready=m_axis_tready.
  - m_axis_tlast = rlast && remaining==0.
  - Any accepted beat with rresp!=0 sets the sticky error flag; the data is still forwarded.
- On accepted rlast:
  - remaining>0: go to ADDR.
  - remaining==0: pulse status with tag/error and return to IDLE.
- Exactly one burst outstanding at a time.
- Arithmetic:
  - remaining is LEN_WIDTH bits.
  - Address increments wrap modulo 2^ADDR_WIDTH; the boundary rule guarantees no burst crosses the wrap.

## Timing
- Reset values:
  - s_desc_ready=0 during rst, 1 the cycle after.
  - m_axi_arvalid=0, m_axi_rready=0, m_axis_tvalid=0, m_status_valid=0, busy=0.
  - araddr/arlen and status payload reset to 0.
- Descriptor accepted in cycle N → arvalid=1 in N+1; burst length is registered, not combinational from s_desc_*.
- AR accepted in cycle M → rready is eligible in M+1.
- Last R beat accepted in cycle K:
  - Next burst: arvalid in K+1.
  - Final burst: m_status_valid in K+1, s_desc_ready in K+1 (same cycle as status).
- rready is never high outside DATA; tvalid never depends on tready.
- rst mid-operation: immediate return to IDLE, no status pulse. The slave must be reset together with this block.

## Structure
- Shared package axi_pkg: AXI burst/resp/cache encodings (BURST_INCR, RESP_OKAY, CACHE_MODIFIABLE_BUFFERABLE) and the 4 KB boundary constant.
- Optional sub-module axi_burst_split: combinational beats/next-address calculator (remaining, addr → arlen, beats), reusable by a future write DMA.
- Everything else is a single module.

## Test plan
- Desc addr=0x0000, len=4, tag=0x11 against an AXI4 RAM slave model → one AR (arlen=3, arsize=2); 4 stream words matching memory; tlast on word 4; status tag=0x11, error=0.
- len=40, MAX_BURST_LEN=16 → AR arlen 15, 15, 7 at addresses 0x0, 0x40, 0x80; 40 words in order; single tlast.
- addr=0x0FF8, len=8 → bursts arlen=1 at 0x0FF8, then arlen=5 at 0x1000; no burst crosses 4 KB.
- m_axis_tready toggled 1-0-1 every cycle during len=16 → rready mirrors tready, no lost or duplicated words, status after the 16th word.
- Slave returns SLVERR on beat 2 of len=4 → all 4 words forwarded, status error=1; the following descriptor reports error=0.
- len=0, tag=0x7 → no arvalid, status pulse with tag=0x7 one cycle after accept; rst asserted mid-burst → arvalid/tvalid low, busy=0, no status.
